debug_display_sel: RTL and testbench

Parametrised, registered debug-value selector that drives the board LCD/7-segment readout from one of NCH WIDTH-bit datapath probes (register read data, write data, next PC, ALU result, …). It extends the one-hot manual selector with an auto-scan mode that cycles through channels on a dwell timer, a freeze control that holds the display, and an invalid-select flag. It sits between the CPU core's probe bus and the display driver.

---
 rtl/debug_display_pkg.sv | 42 ++++
 rtl/display_scan_timer.sv | 53 +++++
 rtl/debug_display_sel.sv | 116 +++++++++++
 tb/tb_debug_display_sel.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/debug_display_pkg.sv
// Shared definitions for the debug display selector: mode encodings,
// one-hot decoding and index-width sizing.
// Pure declarations; no clocked logic, no flow control.
package debug_display_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // Widest select vector the one-hot decoder accepts.
    localparam int MAX_CH = 64;

    typedef struct packed {
        logic        vld;  // exactly one bit set
        logic [31:0] idx;  // position of that bit, 0 when not valid
    } onehot_res_t;

    // Index width for n channels; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Position of the single set bit; zero or multi-hot input reports
    // vld=0 with index 0 so the caller lands on the default channel.
    function automatic onehot_res_t onehot_to_idx(input logic [MAX_CH-1:0] vec);
        onehot_res_t r;
        int unsigned ones;
        r    = '0;
        ones = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (vec[i]) begin
                ones++;
                r.idx = 32'(i);
            end
        end
        r.vld = (ones == 1);
        if (!r.vld) begin
            r.idx = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Dwell counter and wrap-around index incrementer for the auto-scan mode.
// advance_o is combinational from the counter state; count updates on the next edge.
// No flow control: restart_i clears, enable_i counts, neither holds the count.
//
// Ports: CLK/RST (sync, active high); enable_i counts one dwell cycle;
// restart_i clears the count; idx_i is the shown channel, idx_inc_o its
// wrapped successor; advance_o pulses on the last cycle of a dwell period.
module display_scan_timer
    import debug_display_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int DWELL = 50_000_000
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable_i,
    input  logic                      restart_i,
    input  logic [idx_width(NCH)-1:0] idx_i,
    output logic [idx_width(NCH)-1:0] idx_inc_o,
    output logic                      advance_o
);

    localparam int IDXW = idx_width(NCH);
    localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            last_cycle;

    assign last_cycle = (cnt_q == CNTW'(DWELL - 1));
    assign advance_o  = enable_i && last_cycle;

    // Explicit wrap so non-power-of-two channel counts never reach NCH.
    assign idx_inc_o = (idx_i == IDXW'(NCH - 1)) ? '0 : idx_i + IDXW'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = last_cycle ? '0 : cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debug_display_sel.sv
// Registered debug-probe selector for the board readout: manual one-hot or auto-scan.
// Latency: one cycle from SLCT/CH_DATA/MODE to Result/CH_IDX/SEL_ERR.
// No backpressure; FREEZE holds every register including the dwell count.
//
// Ports: CLK, RST (sync, active high); SLCT one-hot manual select;
// MODE 0=manual 1=auto-scan; FREEZE holds display; CH_DATA flattened probes
// (channel k at [k*WIDTH +: WIDTH]); Result/CH_IDX/SEL_ERR registered outputs.
module debug_display_sel
    import debug_display_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 8,
    parameter int DWELL = 50_000_000
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NCH-1:0]            SLCT,
    input  logic                      MODE,
    input  logic                      FREEZE,
    input  logic [NCH*WIDTH-1:0]      CH_DATA,
    output logic [WIDTH-1:0]          Result,
    output logic [idx_width(NCH)-1:0] CH_IDX,
    output logic                      SEL_ERR
);

    localparam int IDXW = idx_width(NCH);

    // idx and CH_IDX always load the same next value on the same edge,
    // so a single register serves as both.
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sel_err_q, sel_err_d;
    logic             prev_mode_q, prev_mode_d;

    logic [MAX_CH-1:0] slct_ext;
    onehot_res_t       oh;
    logic              scan_en;
    logic              scan_restart;
    logic              advance;
    logic [IDXW-1:0]   idx_inc;

    always_comb begin
        slct_ext           = '0;
        slct_ext[NCH-1:0]  = SLCT;
    end

    assign oh = onehot_to_idx(slct_ext);

    // Counting only once auto mode has been seen for a full cycle; the
    // rising edge of MODE (and all of manual mode) clears the dwell count.
    assign scan_en      = !FREEZE && (MODE == MODE_AUTO) && prev_mode_q;
    assign scan_restart = !FREEZE && ((MODE == MODE_MANUAL) || !prev_mode_q);

    display_scan_timer #(
        .NCH   (NCH),
        .DWELL (DWELL)
    ) u_scan_timer (
        .CLK       (CLK),
        .RST       (RST),
        .enable_i  (scan_en),
        .restart_i (scan_restart),
        .idx_i     (idx_q),
        .idx_inc_o (idx_inc),
        .advance_o (advance)
    );

    always_comb begin
        idx_d       = idx_q;
        sel_err_d   = sel_err_q;
        prev_mode_d = prev_mode_q;
        if (!FREEZE) begin
            prev_mode_d = MODE;
            if (MODE == MODE_MANUAL) begin
                idx_d     = oh.vld ? IDXW'(oh.idx) : '0;
                sel_err_d = !oh.vld;
            end else begin
                sel_err_d = 1'b0;
                if (advance) begin
                    idx_d = idx_inc;
                end
            end
        end
    end

    // Data is taken from idx_d so Result and CH_IDX change on the same edge.
    always_comb begin
        result_d = result_q;
        if (!FREEZE) begin
            result_d = '0;
            for (int k = 0; k < NCH; k++) begin
                if (idx_d == IDXW'(k)) begin
                    result_d = CH_DATA[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q       <= '0;
            result_q    <= '0;
            sel_err_q   <= 1'b0;
            prev_mode_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            result_q    <= result_d;
            sel_err_q   <= sel_err_d;
            prev_mode_q <= prev_mode_d;
        end
    end

    assign Result  = result_q;
    assign CH_IDX  = idx_q;
    assign SEL_ERR = sel_err_q;

endmodule

// File: tb/tb_debug_display_sel.sv
module tb_debug_display_sel;

    localparam int WIDTH = 32;
    localparam int NCH   = 5;
    localparam int DWELL = 3;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic                 CLK;
    logic                 RST;
    logic [NCH-1:0]       SLCT;
    logic                 MODE;
    logic                 FREEZE;
    logic [NCH*WIDTH-1:0] CH_DATA;
    logic [WIDTH-1:0]     Result;
    logic [2:0]           CH_IDX;
    logic                 SEL_ERR;

    debug_display_sel #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .DWELL (DWELL)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SLCT    (SLCT),
        .MODE    (MODE),
        .FREEZE  (FREEZE),
        .CH_DATA (CH_DATA),
        .Result  (Result),
        .CH_IDX  (CH_IDX),
        .SEL_ERR (SEL_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  idx;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       frz;
        logic [4:0] slct;
        exp_t       e;
    } vec_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    function automatic exp_t mk(input int idx, input logic err);
        exp_t e;
        e.res = BASE + 32'(idx);
        e.idx = 3'(idx);
        e.err = err;
        return e;
    endfunction

    function automatic vec_t mv(input logic rst, input logic frz,
                                input logic [4:0] slct, input exp_t e);
        vec_t v;
        v.rst  = rst;
        v.frz  = frz;
        v.slct = slct;
        v.e    = e;
        return v;
    endfunction

    task automatic load_base();
        for (int k = 0; k < NCH; k++) begin
            CH_DATA[k*WIDTH +: WIDTH] = BASE + 32'(k);
        end
    endtask

    task automatic check_out();
        exp_t  e;
        string nm;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (Result !== e.res || CH_IDX !== e.idx || SEL_ERR !== e.err) begin
                errors++;
                $display("FAIL %s: got Result=%h CH_IDX=%0d SEL_ERR=%b, want Result=%h CH_IDX=%0d SEL_ERR=%b",
                         nm, Result, CH_IDX, SEL_ERR, e.res, e.idx, e.err);
            end
        end
    endtask

    // Drive one cycle of inputs away from the edge, queue the expectation
    // for the following edge, then compare just after that edge.
    task automatic step(input logic rst, input logic mode, input logic frz,
                        input logic [4:0] slct, input exp_t e, input string nm);
        @(negedge CLK);
        RST    = rst;
        MODE   = mode;
        FREEZE = frz;
        SLCT   = slct;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
        check_out();
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = mv(1'b0, 1'b0, 5'b01000, mk(3, 1'b0));
        tbl[1]  = mv(1'b0, 1'b0, 5'b00000, mk(0, 1'b1));
        tbl[2]  = mv(1'b0, 1'b0, 5'b00110, mk(0, 1'b1));
        tbl[3]  = mv(1'b0, 1'b0, 5'b00001, mk(0, 1'b0));
        tbl[4]  = mv(1'b0, 1'b0, 5'b10000, mk(4, 1'b0));
        tbl[5]  = mv(1'b0, 1'b0, 5'b11111, mk(0, 1'b1));
        tbl[6]  = mv(1'b0, 1'b1, 5'b00010, mk(0, 1'b1));
        tbl[7]  = mv(1'b0, 1'b0, 5'b00010, mk(1, 1'b0));
        tbl[8]  = mv(1'b0, 1'b1, 5'b00100, mk(1, 1'b0));
        tbl[9]  = mv(1'b0, 1'b0, 5'b00100, mk(2, 1'b0));
        tbl[10] = mv(1'b1, 1'b1, 5'b01000, 37'h0);
        tbl[11] = mv(1'b0, 1'b0, 5'b01000, mk(3, 1'b0));

        RST = 1'b1; MODE = 1'b0; FREEZE = 1'b0; SLCT = '0; CH_DATA = '0;

        // Reset with random inputs on every other pin.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NCH; k++) CH_DATA[k*WIDTH +: WIDTH] = $urandom;
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom), 37'h0, "reset");
        end
        load_base();

        // Manual selection, invalid selects, freeze and reset priority.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, 1'b0, tbl[i].frz, tbl[i].slct, tbl[i].e,
                 $sformatf("vec%0d", i));
        end

        // Auto-scan from channel 3 with wrap, SLCT ignored (all zero).
        step(1'b0, 1'b0, 1'b0, 5'b01000, mk(3, 1'b0), "pre_scan_sel3");
        for (int n = 0; n < 14; n++) begin
            step(1'b0, 1'b1, 1'b0, 5'b00000, mk((3 + n / 3) % 5, 1'b0),
                 $sformatf("scan%0d", n));
        end

        // Freeze one cycle into channel 2's dwell while probes change.
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < NCH; k++) CH_DATA[k*WIDTH +: WIDTH] = $urandom;
            step(1'b0, 1'b1, 1'b1, 5'($urandom), mk(2, 1'b0),
                 $sformatf("freeze%0d", i));
        end
        load_base();
        step(1'b0, 1'b1, 1'b0, 5'b00000, mk(2, 1'b0), "thaw_remaining");
        step(1'b0, 1'b1, 1'b0, 5'b00000, mk(3, 1'b0), "thaw_advance");

        // Reset mid-scan overrides FREEZE; scan restarts from 0, full dwell.
        step(1'b0, 1'b0, 1'b0, 5'b00100, mk(2, 1'b0), "sel2");
        step(1'b0, 1'b1, 1'b0, 5'b00000, mk(2, 1'b0), "auto_start2");
        step(1'b0, 1'b1, 1'b0, 5'b00000, mk(2, 1'b0), "auto_hold2");
        step(1'b1, 1'b1, 1'b1, 5'b00000, 37'h0, "rst_mid_scan");
        for (int n = 0; n < 7; n++) begin
            step(1'b0, 1'b1, 1'b0, 5'b00000, mk(n / 3, 1'b0),
                 $sformatf("rescan%0d", n));
        end

        // Mode falling: manual select applies on the next edge.
        step(1'b0, 1'b0, 1'b0, 5'b10000, mk(4, 1'b0), "mode_fall_sel4");

        // Outputs must not follow inputs between edges.
        CH_DATA = ~CH_DATA;
        SLCT    = 5'b00001;
        #1;
        checks++;
        if (Result !== BASE + 32'd4 || CH_IDX !== 3'd4) begin
            errors++;
            $display("FAIL no_comb_path: got Result=%h CH_IDX=%0d, want Result=%h CH_IDX=4",
                     Result, CH_IDX, BASE + 32'd4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
